// File: rtl/load_writeback_unit_pkg.sv
// Shared types and helpers for the load/writeback unit.
// Pure declarations: no logic, no latency.
// Has no flow control of its own.
package lwb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        WB    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Natural alignment: the low 'size' address bits must be zero.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE:  mis = 1'b0;
            SZ_HALF:  mis = addr_lo[0];
            SZ_WORD:  mis = |addr_lo[1:0];
            SZ_DWORD: mis = |addr_lo[2:0];
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_writeback_unit_align.sv
// Selects the addressed byte/half/word lane of a memory word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module load_align #(
    parameter int DATA_W = 32,
    localparam int LSB_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [LSB_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              sgn,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] msb;
    logic [6:0]        nbits;

    always_comb begin
        lane  = data >> {offset, 3'b000};
        nbits = 7'd8 << size;
        keep  = ~({DATA_W{1'b1}} << nbits);
        msb   = {{(DATA_W-1){1'b0}}, 1'b1} << (nbits - 7'd1);
        // A full-width access has nothing to extend.
        if (nbits >= 7'(DATA_W)) begin
            result = lane;
        end else if (sgn && (|(lane & msb))) begin
            result = lane | ~keep;
        end else begin
            result = lane & keep;
        end
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load unit: one request -> aligned memory read -> extended register write.
// Latency: >= 3 cycles accept-to-writeback, +1 per request or response stall cycle.
// Backpressure: ld_ready only in IDLE; mem request held stable until mem_req_ready.
module load_writeback_unit
    import lwb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              ld_err,
    output logic              busy
);

    localparam int LSB_W  = $clog2(DATA_W / 8);
    localparam int SIZE_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic              sgn;
        logic [REG_AW-1:0] rd;
    } ld_req_t;

    state_t            state_q;
    ld_req_t           req_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              err_q;
    logic              illegal_req;
    logic [DATA_W-1:0] aligned;

    assign illegal_req = (ld_size > SIZE_W'(LSB_W)) || is_misaligned(ld_addr[2:0], ld_size);

    load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .data   (mem_rsp_data),
        .offset (req_q.addr[LSB_W-1:0]),
        .size   (req_q.size),
        .sgn    (req_q.sgn),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_valid) begin
                        if (illegal_req) begin
                            err_q <= 1'b1;
                        end else begin
                            req_q   <= '{addr: ld_addr, size: ld_size, sgn: ld_signed, rd: ld_rd};
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Once the request is accepted a response is owed and must be drained.
                    if (mem_req_ready) begin
                        state_q <= flush ? DRAIN : WAIT;
                    end else if (flush) begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            wb_data_q <= aligned;
                            state_q   <= WB;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rsp_valid) begin
                        state_q <= IDLE;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = {req_q.addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
    // x0 is hardwired zero, so the write strobe is dropped but the WB cycle is kept.
    assign wb_we         = (state_q == WB) && (req_q.rd != '0);
    assign wb_addr       = req_q.rd;
    assign wb_data       = wb_data_q;
    assign ld_err        = err_q;

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle load-data/writeback mux.
- Accepts one load request from the decode/execute stage and issues a word-aligned read to data memory over a valid/ready request channel.
- Waits for a response of any latency, then extracts and sign- or zero-extends the addressed byte, half or word.
- Issues a single-cycle register-file write. Supports misalignment detection and a pipeline flush that can drop an in-flight response.

Parameters:
- DATA_W, 32, memory and register data width; power of two, 16 to 64.
- REG_AW, 5, register index width.
- ADDR_W, 32, byte address width.
- Derived (not overridable): LSB_W = log2(DATA_W/8); SIZE_W = 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load request present
- ld_ready  out  1  unit can accept a request
- ld_addr  in  ADDR_W  byte address
- ld_size  in  SIZE_W  log2 bytes: 0=byte, 1=half, 2=word, 3=dword
- ld_signed  in  1  1=sign-extend, 0=zero-extend
- ld_rd  in  REG_AW  destination register
- flush  in  1  abandon the current load
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_addr  out  ADDR_W  word-aligned address (low LSB_W bits zero)
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  DATA_W  full memory word
- wb_we  out  1  register-file write strobe
- wb_addr  out  REG_AW  write index
- wb_data  out  DATA_W  write data
- ld_err  out  1  one-cycle misalignment/illegal-size pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All captured registers are cleared.
  - mem_req_valid=0, wb_we=0, wb_addr=0, wb_data=0, ld_err=0, busy=0.
  - ld_ready=1 once reset deasserts.
  - Reset mid-operation discards everything. Any later mem_rsp_valid is ignored.
- States: IDLE, REQ, WAIT, DRAIN, WB.
- IDLE:
  - ld_ready=1.
  - On ld_valid, capture addr, size, signed and rd.
  - An illegal request is one where ld_size > LSB_W or ld_addr mod 2^ld_size != 0. It pulses ld_err for the next cycle, makes no memory access and no writeback, and the unit stays in IDLE.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1 and mem_addr = captured addr with low LSB_W bits cleared. Both are held stable until mem_req_ready.
  - mem_req_valid & mem_req_ready -> WAIT.
  - flush with no handshake that cycle -> IDLE. The request is withdrawn.
  - flush together with the handshake -> DRAIN.
- WAIT:
  - mem_rsp_valid -> register the extracted data into wb_data and go to WB.
  - flush -> DRAIN.
  - If flush and mem_rsp_valid occur together, the response is discarded and the unit goes to IDLE.
- DRAIN:
  - Waits for exactly one mem_rsp_valid, discards it, then goes to IDLE.
  - flush has no effect here.
- WB:
  - wb_we=1 for exactly one cycle, wb_addr=rd, then go to IDLE.
  - wb_we is suppressed when rd==0; the state still passes through WB.
  - flush in WB is ignored because the write has already committed.
- Extraction:
  - lane = mem_rsp_data >> (addr[LSB_W-1:0]*8).
  - Keep the low 8<<size bits.
  - If signed, fill the upper bits with bit (8<<size)-1; otherwise fill with zeros.
  - Size == LSB_W passes the full word unchanged.
- mem_rsp_valid in IDLE, REQ or WB is ignored.
- ld_ready=0 in every state except IDLE. Only one load is in flight at a time.
- Latency: if the request is accepted at edge E0, mem_req_ready=1 in cycle 1, and the response arrives in cycle 2, then wb_we is high in cycle 3. That is a minimum of 3 cycles from accept to writeback. Each memory stall cycle adds one.
- wb_data holds its value after WB until the next capture.

Decomposition:
- Package lwb_pkg holds:
  - State enum {IDLE, REQ, WAIT, DRAIN, WB}.
  - Size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3.
  - Function is_misaligned(addr, size).
- One combinational sub-module, load_align, takes (data, offset, size, signed) and returns the extended word. It is parametrised by DATA_W and unit-tested on its own.
- The top level contains the FSM, capture registers and handshake.

Test Plan:
- Byte load, signed, addr=0x1003, rd=8, mem_rsp_data=0x80AB_CDEF, req_ready and rsp both immediate -> wb_we pulses 3 cycles after accept with wb_addr=8 and wb_data=0xFFFF_FF80. With ld_signed=0 -> wb_data=0x0000_0080.
- Half load, signed, addr=0x2002, data=0x7FFF_1234, mem_req_ready delayed 4 cycles, rsp delayed 5 cycles -> mem_addr=0x2000 held stable while stalled; wb_data=0x0000_7FFF; busy high throughout; ld_ready low.
- Half load at addr=0x3001 -> ld_err pulses one cycle; mem_req_valid never rises; wb_we stays 0. Repeat with ld_size=3 at DATA_W=32 -> same response.
- Flush in WAIT, then a response with data=0xDEAD_BEEF, then a new word load at 0x40 with data=0x1234_5678 -> the first response is dropped and only one wb_we occurs, with wb_data=0x1234_5678.
- Word load with rd=0 -> full handshake completes and wb_we stays 0. Separately, assert rst_n low while in WAIT and deliver a response after release -> no writeback; all outputs at reset values.
- DATA_W=64 build, dword load at 0x8, data=0x8000_0000_0000_0001, signed -> wb_data equals the data unchanged. Byte load at offset 7 -> sign extension taken from bit 63.
